proc_sequencer: RTL and testbench

PROC_SEQUENCER -- requirements
Module: proc_sequencer

---
 rtl/proc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_proc_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// -----------------------------------------------------------------------------
// proc_sequencer
//
// Walks an instruction ROM from address 0 and hands each word to a processor,
// one instruction at a time. Every instruction goes through three phases:
//   FETCH - rom_addr holds the instruction address while the ROM reads it
//   LOAD  - the ROM word is registered onto proc_din and proc_run is raised
//   WAIT  - proc_din is held until the processor answers with proc_done
// If the processor does not answer within TIMEOUT WAIT cycles, the block
// parks in ERROR until abort or reset. A zero-length program completes at
// once: finished pulses and neither the ROM nor the processor is touched.
//
// Ports
//   clk_50MHz  in   1   system clock, all state changes on its rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   begin a program at address 0 (looked at in IDLE only)
//   abort      in   1   synchronous cancel, wins over everything but reset
//   prog_len   in   9   instruction count 0..256, captured on accepted start
//   rom_addr   out  8   registered instruction ROM address
//   rom_data   in   16  ROM read data, valid one cycle after rom_addr changes
//   proc_din   out  16  registered instruction word for the processor
//   proc_run   out  1   one-cycle pulse, proc_din valid in that cycle
//   proc_done  in   1   processor completion pulse, heeded in WAIT only
//   busy       out  1   high in FETCH, LOAD and WAIT
//   finished   out  1   one-cycle pulse after the last instruction completes
//   error      out  1   high while parked in ERROR
// -----------------------------------------------------------------------------
module proc_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [8:0]  prog_len,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] proc_din,
    output logic        proc_run,
    input  logic        proc_done,
    output logic        busy,
    output logic        finished,
    output logic        error
);

    // The watchdog counts 0..TIMEOUT-1; the WAIT cycle in which it holds
    // TIMEOUT-1 is the last one allowed.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      pc;
    logic [7:0]      pc_nxt;
    logic [8:0]      len_reg;
    logic [8:0]      len_nxt;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] watchdog_nxt;
    logic [15:0]     proc_din_nxt;
    logic            proc_run_nxt;
    logic            finished_nxt;

    logic            last_instr;
    logic            wd_expired;

    // pc is 8 bits and len_reg 9 bits: with len_reg=256 the last address is
    // 255, so pc reaches the final instruction without ever wrapping.
    assign last_instr = ({1'b0, pc} == (len_reg - 9'd1));
    assign wd_expired = (watchdog == WD_LAST);

    // The ROM address register is the program counter itself: it only moves
    // on an accepted start (to 0) or on a completed non-final instruction.
    assign rom_addr = pc;

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            len_reg  <= '0;
            watchdog <= '0;
            proc_din <= '0;
            proc_run <= 1'b0;
            finished <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            len_reg  <= len_nxt;
            watchdog <= watchdog_nxt;
            proc_din <= proc_din_nxt;
            proc_run <= proc_run_nxt;
            finished <= finished_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (prog_len != 9'd0)) begin
                        state_nxt = S_FETCH;
                    end
                end
                S_FETCH: state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_WAIT;
                S_WAIT: begin
                    // A completion in the same cycle as the last permitted
                    // WAIT cycle still counts as a completion.
                    if (proc_done) begin
                        state_nxt = last_instr ? S_IDLE : S_FETCH;
                    end else if (wd_expired) begin
                        state_nxt = S_ERROR;
                    end
                end
                S_ERROR: state_nxt = S_ERROR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: status flags and next values of the registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy         = (state == S_FETCH) || (state == S_LOAD) || (state == S_WAIT);
        error        = (state == S_ERROR);
        pc_nxt       = pc;
        len_nxt      = len_reg;
        watchdog_nxt = watchdog;
        proc_din_nxt = proc_din;
        proc_run_nxt = 1'b0;
        finished_nxt = 1'b0;

        // abort leaves every datapath register where it is (proc_din in
        // particular) and suppresses both pulses.
        if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len != 9'd0) begin
                            len_nxt = prog_len;
                            pc_nxt  = 8'd0;
                        end else begin
                            finished_nxt = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    proc_din_nxt = rom_data;
                    proc_run_nxt = 1'b1;
                    watchdog_nxt = '0;
                end
                S_WAIT: begin
                    if (proc_done) begin
                        if (last_instr) begin
                            finished_nxt = 1'b1;
                        end else begin
                            pc_nxt = pc + 8'd1;
                        end
                    end else if (!wd_expired) begin
                        watchdog_nxt = watchdog + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Design invariants
    // -------------------------------------------------------------------------
    // proc_run is only ever visible in the first WAIT cycle of an instruction,
    // so a new run can never overlap an outstanding one.
    a_run_in_wait : assert property (
        @(posedge clk_50MHz) disable iff (!reset_n)
        proc_run |-> (state == S_WAIT)
    );

    a_run_single : assert property (
        @(posedge clk_50MHz) disable iff (!reset_n)
        proc_run |=> !proc_run
    );

endmodule

// File: tb/tb_proc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proc_sequencer
//
// Drives proc_sequencer with a behavioural ROM and a processor stub that
// answers each proc_run after a chosen delay. Whenever a program is started,
// the words the processor must receive (address, ROM contents) are queued;
// a monitor pops one entry per observed proc_run. Directed sequences cover
// latency, zero-length programs, the watchdog, reset and abort; the rest is
// random programs with random ROM contents and stray start pulses.
// -----------------------------------------------------------------------------
module tb_proc_sequencer;

    localparam int TIMEOUT = 16;

    logic        clk_50MHz = 1'b0;
    logic        reset_n   = 1'b1;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic [8:0]  prog_len  = '0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data  = '0;
    logic [15:0] proc_din;
    logic        proc_run;
    logic        proc_done = 1'b0;
    logic        busy;
    logic        finished;
    logic        error;

    always #10 clk_50MHz = ~clk_50MHz;

    proc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .prog_len  (prog_len),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .proc_din  (proc_din),
        .proc_run  (proc_run),
        .proc_done (proc_done),
        .busy      (busy),
        .finished  (finished),
        .error     (error)
    );

    // Synchronous ROM: data follows the address by one clock.
    logic [15:0] rom [256];
    always @(posedge clk_50MHz) rom_data <= rom[rom_addr];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   run_times[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   run_cnt  = 0;
    int   fin_seen = 0;
    int   fin_exp  = 0;

    // Processor stub controls, written by the stimulus just after a rising
    // edge and read by the stub on the falling edge.
    bit   respond    = 1'b1;
    int   done_delay = 0;
    bit   done_force = 1'b0;
    int   countdown  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #2;
    endtask

    // Processor stub: proc_done follows a seen proc_run by done_delay cycles
    // (0 means in the run cycle itself); done_force adds a manual pulse.
    always @(negedge clk_50MHz) begin
        logic d;
        d = done_force;
        if (countdown == 0) begin
            d = 1'b1;
            countdown = -1;
        end else if (countdown > 0) begin
            countdown--;
        end
        if (proc_run && respond) begin
            if (done_delay == 0) d = 1'b1;
            else countdown = done_delay - 1;
        end
        proc_done = d;
    end

    // Monitor: one queue entry per proc_run, finished pulses counted.
    always @(posedge clk_50MHz) begin
        exp_t e;
        cyc++;
        #1;
        if (proc_run) begin
            run_cnt++;
            run_times.push_back(cyc + 1);
            if (exp_q.size() == 0) begin
                check("unexpected_run", 32'(rom_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("run_addr", 32'(rom_addr), 32'(e.addr));
                check("run_din", 32'(proc_din), 32'(e.word));
            end
        end
        if (finished) fin_seen++;
    end

    // Issue a start for one cycle. With accept set, the model queues the
    // program's words; with fin set, it expects one finished pulse.
    task automatic start_prog(input int len, input bit accept, input bit fin, output int edge_n);
        start    = 1'b1;
        prog_len = 9'(len);
        edge_n   = cyc + 1;
        if (accept) begin
            for (int i = 0; i < len; i++) exp_q.push_back('{8'(i), rom[i]});
            if (fin) fin_exp++;
        end
        tick();
        start    = 1'b0;
        prog_len = 9'($urandom_range(0, 511));
    endtask

    task automatic wait_done(input int budget, input bit noise);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            // Stray starts only while runs remain, so the block is busy.
            if (noise && exp_q.size() > 0 && $urandom_range(0, 7) == 0) begin
                start    = 1'b1;
                prog_len = 9'($urandom_range(0, 511));
            end
            tick();
            start = 1'b0;
            k++;
        end
        check("wait_budget", 32'(exp_q.size() == 0 && !busy), 32'd1);
        tick();
    endtask

    task automatic end_check(input string name);
        check({name, "_fin"}, 32'(fin_seen), 32'(fin_exp));
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic wait_runs(input int target, input int budget);
        int k;
        k = 0;
        while (run_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check("wait_runs", 32'(run_cnt >= target), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        int addr0;
        int runs0;
        int err_cyc;
        int len;

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

        // Reset state
        #1 reset_n = 1'b0;
        tick();
        tick();
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_proc_din", 32'(proc_din), 32'd0);
        check("rst_proc_run", 32'(proc_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset_n = 1'b1;
        tick();

        // Three-word program, done two cycles after each run
        rom[0] = 16'h101C;
        rom[1] = 16'h0200;
        rom[2] = 16'h721B;
        done_delay = 2;
        start_prog(3, 1'b1, 1'b1, n);
        wait_done(100, 1'b0);
        end_check("three_word");

        // Latency: done in the run cycle, runs at N+3 and N+6
        done_delay = 0;
        run_times.delete();
        start_prog(2, 1'b1, 1'b1, n);
        wait_done(100, 1'b0);
        check("lat_runs", 32'(run_times.size()), 32'd2);
        if (run_times.size() >= 2) begin
            check("lat_first", 32'(run_times[0]), 32'(n + 3));
            check("lat_second", 32'(run_times[1]), 32'(n + 6));
        end
        end_check("latency");

        // Zero-length program
        addr0 = int'(rom_addr);
        runs0 = run_cnt;
        start_prog(0, 1'b1, 1'b1, n);
        check("zero_fin_pulse", 32'(finished), 32'd1);
        check("zero_addr", 32'(rom_addr), 32'(addr0));
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_fin_once", 32'(finished), 32'd0);
        tick();
        check("zero_no_run", 32'(run_cnt), 32'(runs0));
        end_check("zero_len");

        // Watchdog: first instruction never answered
        respond = 1'b0;
        run_times.delete();
        exp_q.push_back('{8'd0, rom[0]});
        start_prog(2, 1'b0, 1'b0, n);
        k = 0;
        while (!error && k < 60) begin
            tick();
            k++;
        end
        err_cyc = cyc + 1;
        check("wd_error", 32'(error), 32'd1);
        if (run_times.size() >= 1)
            check("wd_time", 32'(err_cyc), 32'(run_times[0] + TIMEOUT));
        check("wd_busy", 32'(busy), 32'd0);
        start_prog(3, 1'b0, 1'b0, n);
        tick();
        tick();
        check("wd_start_ignored", 32'(error), 32'd1);
        check("wd_no_run", 32'(exp_q.size()), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("wd_abort_error", 32'(error), 32'd0);
        check("wd_abort_busy", 32'(busy), 32'd0);
        respond = 1'b1;
        tick();
        check("wd_fin", 32'(fin_seen), 32'(fin_exp));

        // Reset during WAIT of instruction 1, then a clean restart
        done_delay = 3;
        runs0 = run_cnt;
        start_prog(3, 1'b1, 1'b0, n);
        wait_runs(runs0 + 2, 60);
        reset_n = 1'b0;
        #1;
        check("arst_rom_addr", 32'(rom_addr), 32'd0);
        check("arst_proc_din", 32'(proc_din), 32'd0);
        check("arst_proc_run", 32'(proc_run), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_finished", 32'(finished), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("arst_idle", 32'(busy), 32'd0);
        done_delay = 1;
        start_prog(2, 1'b1, 1'b1, n);
        wait_done(100, 1'b0);
        end_check("after_reset");

        // abort together with proc_done in the last instruction's WAIT
        done_delay = 2;
        runs0 = run_cnt;
        start_prog(2, 1'b1, 1'b0, n);
        wait_runs(runs0 + 2, 60);
        respond    = 1'b0;
        done_force = 1'b1;
        abort      = 1'b1;
        tick();
        done_force = 1'b0;
        abort      = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fin", 32'(finished), 32'd0);
        check("abort_din", 32'(proc_din), 32'(rom[1]));
        tick();
        tick();
        respond = 1'b1;
        end_check("abort_done");

        // Random programs, including a full 256-word one
        for (int p = 0; p < 24; p++) begin
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
            len        = (p == 0) ? 256 : int'($urandom_range(1, 12));
            done_delay = int'($urandom_range(0, 4));
            start_prog(len, 1'b1, 1'b1, n);
            wait_done(len * 12 + 50, 1'b1);
            end_check("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running at t=%0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
